// File: rtl/aes_pkg.sv
// ---------------------------------------------------------------------------
// aes_pkg
// Shared types, constants and helpers for the iterative AES-128 sequencer.
//
// Contents
//   aes_state_t     128-bit AES state / round-key word, byte 0 at [127:120],
//                   column-major (byte index = 4*column + row)
//   NR              number of rounds for AES-128
//   RCON_INIT       round constant used by the key-expansion step of round 1
//   ROUND_W         width of a counter that holds 0..NR
//   aes_ctrl_fsm_e  controller states
//   xtime()         multiply-by-x in GF(2^8) modulo x^8+x^4+x^3+x+1
// ---------------------------------------------------------------------------
package aes_pkg;

    typedef logic [127:0] aes_state_t;

    localparam int         NR        = 10;
    localparam logic [7:0] RCON_INIT = 8'h01;
    localparam int         ROUND_W   = $clog2(NR + 1);

    // IDLE : waiting for a plaintext/key pair
    // ROUND: one AES round per cycle through the external datapath
    // DONE : ciphertext presented until the consumer takes it
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUND = 2'd1,
        DONE  = 2'd2
    } aes_ctrl_fsm_e;

    // Successive applications starting at 8'h01 give the AES-128 round
    // constants 01,02,04,08,10,20,40,80,1b,36.
    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

endpackage : aes_pkg

// File: rtl/aes_rcon_gen.sv
// ---------------------------------------------------------------------------
// aes_rcon_gen
// Round-constant register for the key-expansion step. Loaded with RCON_INIT
// when a block is accepted, advanced by xtime() once per round.
//
// Parameters
//   RCON_INIT  constant loaded by reset and by load
//
// Ports
//   clk   in   1   clock, rising edge
//   rst   in   1   synchronous, active-high reset (rcon <= RCON_INIT)
//   load  in   1   restart the sequence at RCON_INIT (priority over step)
//   step  in   1   advance to xtime(rcon)
//   rcon  out  8   current round constant
// ---------------------------------------------------------------------------
module aes_rcon_gen #(
    parameter logic [7:0] RCON_INIT = aes_pkg::RCON_INIT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic       step,
    output logic [7:0] rcon
);

    import aes_pkg::xtime;

    logic [7:0] rcon_q;

    // NOTE: registers are written with non-blocking assignments so every
    // flop samples values from before the edge, independent of block order.
    always_ff @(posedge clk) begin
        if (rst) begin
            rcon_q <= RCON_INIT;
        end else if (load) begin
            rcon_q <= RCON_INIT;
        end else if (step) begin
            rcon_q <= xtime(rcon_q);
        end
    end

    assign rcon = rcon_q;

endmodule : aes_rcon_gen

// File: rtl/aes_round_ctrl.sv
// ---------------------------------------------------------------------------
// aes_round_ctrl
// Iterative AES-128 encryption sequencer. Holds the 128-bit state and the
// round-key registers and steps an external combinational round datapath
// and key-expansion step through NR rounds, one round per cycle.
//
// Build option
//   AES_OUT_REG_EN  when defined, ct_o/out_valid_o come from a dedicated
//                   output register filled in the first DONE cycle; the
//                   state register is cleared at the same time and the
//                   accept-to-valid latency grows from NR+1 to NR+2.
//
// Parameters
//   NR         number of rounds (10 for AES-128)
//   RCON_INIT  round constant for round 1
//
// Ports
//   clk_i          in   1    clock, rising edge
//   rst_i          in   1    synchronous, active-high reset
//   in_valid_i     in   1    plaintext/key presented
//   in_ready_o     out  1    high only in IDLE
//   pt_i           in   128  plaintext
//   key_i          in   128  cipher key
//   state_o        out  128  state register, to the round datapath
//   key_o          out  128  round-key register, to key expansion
//   rcon_o         out  8    round constant for this cycle's key step
//   mix_en_o       out  1    MixColumns enable, low in the final round
//   round_o        out  4    1..NR while in ROUND, 0 otherwise
//   rk_next_i      in   128  next round key from key expansion
//   round_state_i  in   128  round-datapath result using rk_next_i
//   out_valid_o    out  1    ciphertext valid
//   out_ready_i    in   1    consumer accepts ciphertext
//   ct_o           out  128  ciphertext, stable while stalled
// ---------------------------------------------------------------------------
module aes_round_ctrl #(
    parameter int         NR        = aes_pkg::NR,
    parameter logic [7:0] RCON_INIT = aes_pkg::RCON_INIT
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         in_valid_i,
    output logic         in_ready_o,
    input  logic [127:0] pt_i,
    input  logic [127:0] key_i,
    output logic [127:0] state_o,
    output logic [127:0] key_o,
    output logic [7:0]   rcon_o,
    output logic         mix_en_o,
    output logic [3:0]   round_o,
    input  logic [127:0] rk_next_i,
    input  logic [127:0] round_state_i,
    output logic         out_valid_o,
    input  logic         out_ready_i,
    output logic [127:0] ct_o
);

    import aes_pkg::*;

    localparam int              RW         = $clog2(NR + 1);
    localparam logic [RW-1:0]   ROUND_ONE  = RW'(1);
    localparam logic [RW-1:0]   ROUND_LAST = RW'(NR);

    aes_ctrl_fsm_e fsm_q;
    aes_state_t    state_q;
    aes_state_t    key_q;
    logic [RW-1:0] round_q;
    logic [7:0]    rcon;

    logic          accept;
    logic          in_round;
    logic          last_round;

    assign accept     = (fsm_q == IDLE) && in_valid_i;
    assign in_round   = (fsm_q == ROUND);
    assign last_round = (round_q == ROUND_LAST);

    aes_rcon_gen #(
        .RCON_INIT (RCON_INIT)
    ) u_rcon_gen (
        .clk  (clk_i),
        .rst  (rst_i),
        .load (accept),
        .step (in_round),
        .rcon (rcon)
    );

`ifdef AES_OUT_REG_EN
    aes_state_t ct_q;
    logic       out_valid_q;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            // A reset mid-block simply drops it; nothing reaches the output.
            fsm_q   <= IDLE;
            state_q <= '0;
            key_q   <= '0;
            round_q <= '0;
`ifdef AES_OUT_REG_EN
            ct_q        <= '0;
            out_valid_q <= 1'b0;
`endif
        end else begin
            case (fsm_q)
                IDLE: begin
                    if (in_valid_i) begin
                        // Initial AddRoundKey with the cipher key itself.
                        state_q <= pt_i ^ key_i;
                        key_q   <= key_i;
                        round_q <= ROUND_ONE;
                        fsm_q   <= ROUND;
                    end
                end

                ROUND: begin
                    state_q <= round_state_i;
                    key_q   <= rk_next_i;
                    if (last_round) begin
                        round_q <= '0;
                        fsm_q   <= DONE;
                    end else begin
                        round_q <= round_q + ROUND_ONE;
                    end
                end

                DONE: begin
`ifdef AES_OUT_REG_EN
                    // First DONE cycle moves the result into the output
                    // register; later cycles wait for the handshake.
                    if (!out_valid_q) begin
                        ct_q        <= state_q;
                        out_valid_q <= 1'b1;
                        state_q     <= '0;
                    end else if (out_ready_i) begin
                        out_valid_q <= 1'b0;
                        fsm_q       <= IDLE;
                    end
`else
                    // IDLE is entered without accepting in the same cycle,
                    // so in_ready_o rises one cycle after the handshake.
                    if (out_ready_i) begin
                        fsm_q <= IDLE;
                    end
`endif
                end

                default: fsm_q <= IDLE;
            endcase
        end
    end

    assign in_ready_o = (fsm_q == IDLE);
    assign state_o    = state_q;
    assign key_o      = key_q;

    // Round-related outputs only matter in ROUND; outside it they are
    // parked at fixed values so downstream logic never sees stale data.
    assign rcon_o   = in_round ? rcon : RCON_INIT;
    assign mix_en_o = in_round && !last_round;
    assign round_o  = in_round ? 4'(round_q) : 4'd0;

`ifdef AES_OUT_REG_EN
    assign out_valid_o = out_valid_q;
    assign ct_o        = ct_q;
`else
    assign out_valid_o = (fsm_q == DONE);
    assign ct_o        = state_q;
`endif

endmodule : aes_round_ctrl

// File: tb/tb_aes_round_ctrl.sv
// ---------------------------------------------------------------------------
// tb_aes_round_ctrl
// Self-checking bench for aes_round_ctrl. Supplies the external round
// datapath and key expansion as behavioural functions, and compares the
// ciphertext against a whole-block AES-128 reference and the FIPS-197 C.1
// vector. Honours AES_OUT_REG_EN for the expected latency.
// ---------------------------------------------------------------------------
module tb_aes_round_ctrl;

    localparam int NR = 10;
`ifdef AES_OUT_REG_EN
    localparam int LAT = NR + 2;
`else
    localparam int LAT = NR + 1;
`endif
    localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] pt;
    logic [127:0] key;
    logic [127:0] dut_state;
    logic [127:0] dut_key;
    logic [7:0]   rcon;
    logic         mix_en;
    logic [3:0]   round;
    logic [127:0] rk_next;
    logic [127:0] round_state;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] ct;

    int checks = 0;
    int errors = 0;

    logic [7:0] rcon_tbl [10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                  8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};

    always #5 clk = ~clk;

    aes_round_ctrl dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .in_valid_i    (in_valid),
        .in_ready_o    (in_ready),
        .pt_i          (pt),
        .key_i         (key),
        .state_o       (dut_state),
        .key_o         (dut_key),
        .rcon_o        (rcon),
        .mix_en_o      (mix_en),
        .round_o       (round),
        .rk_next_i     (rk_next),
        .round_state_i (round_state),
        .out_valid_o   (out_valid),
        .out_ready_i   (out_ready),
        .ct_o          (ct)
    );

    // ---------------- AES behavioural helpers ----------------
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // S-box from its definition: GF(2^8) inverse (a^254) then the affine map.
    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] sq;
        logic [7:0] inv;
        sq  = a;
        inv = 8'h01;
        for (int i = 1; i < 8; i++) begin
            sq  = gmul(sq, sq);
            inv = gmul(inv, sq);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [127:0] aes_round(input logic [127:0] s,
                                               input logic [127:0] rk,
                                               input logic mix);
        logic [7:0]   a [16];
        logic [7:0]   t [16];
        logic [7:0]   a0, a1, a2, a3;
        logic [127:0] r;
        for (int i = 0; i < 16; i++) a[i] = sbox(s[127-8*i -: 8]);
        for (int c = 0; c < 4; c++)
            for (int rw = 0; rw < 4; rw++)
                t[4*c+rw] = a[4*((c+rw)%4)+rw];
        if (mix) begin
            for (int c = 0; c < 4; c++) begin
                a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
                a[4*c]   = gmul(8'h02, a0) ^ gmul(8'h03, a1) ^ a2 ^ a3;
                a[4*c+1] = a0 ^ gmul(8'h02, a1) ^ gmul(8'h03, a2) ^ a3;
                a[4*c+2] = a0 ^ a1 ^ gmul(8'h02, a2) ^ gmul(8'h03, a3);
                a[4*c+3] = gmul(8'h03, a0) ^ a1 ^ a2 ^ gmul(8'h02, a3);
            end
        end else begin
            a = t;
        end
        for (int i = 0; i < 16; i++) r[127-8*i -: 8] = a[i];
        return r ^ rk;
    endfunction

    function automatic logic [127:0] key_step(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] w0, w1, w2, w3, t;
        {w0, w1, w2, w3} = k;
        t  = {sbox(w3[23:16]) ^ rc, sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])};
        w0 = w0 ^ t;
        w1 = w1 ^ w0;
        w2 = w2 ^ w1;
        w3 = w3 ^ w2;
        return {w0, w1, w2, w3};
    endfunction

    // Whole-block reference: full key schedule first, then the rounds.
    function automatic logic [127:0] aes_ref(input logic [127:0] p, input logic [127:0] k);
        logic [127:0] rk [NR+1];
        logic [7:0]   rc;
        logic [127:0] s;
        rk[0] = k;
        rc    = 8'h01;
        for (int r = 1; r <= NR; r++) begin
            rk[r] = key_step(rk[r-1], rc);
            rc    = gmul(rc, 8'h02);
        end
        s = p ^ rk[0];
        for (int r = 1; r <= NR; r++) s = aes_round(s, rk[r], r != NR);
        return s;
    endfunction

    // External datapath driven from the controller's outputs.
    always_comb begin
        rk_next     = key_step(dut_key, rcon);
        round_state = aes_round(dut_state, rk_next, mix_en);
    end

    // ---------------- bench utilities ----------------
    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [127:0] rand128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // Runs one block from IDLE: accept, optional per-round trace, optional
    // busy pulse in round 4, bp cycles of backpressure, then handshake.
    task automatic run_block(input logic [127:0] p, input logic [127:0] k,
                             input logic [127:0] exp_ct, input int bp,
                             input bit busy, input bit trace);
        int           cyc;
        logic [127:0] held;
        check("accept_ready", {127'd0, in_ready}, 128'd1);
        pt        = p;
        key       = k;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        step();
        in_valid = 1'b0;
        pt       = rand128();
        key      = rand128();
        cyc      = 1;
        while (!out_valid && cyc < 40) begin
            if (trace && cyc <= NR) begin
                check("round_o", 128'(round), 128'(cyc));
                check("rcon_o", 128'(rcon), 128'(rcon_tbl[cyc-1]));
                check("mix_en_o", 128'(mix_en), 128'(cyc != NR));
            end
            if (busy && cyc == 4) begin
                in_valid = 1'b1;
                check("busy_ready", 128'(in_ready), 128'd0);
            end else begin
                in_valid = 1'b0;
            end
            step();
            cyc++;
        end
        in_valid = 1'b0;
        check("latency", 128'(cyc), 128'(LAT));
        check("ct", ct, exp_ct);
        check("done_round", 128'(round), 128'd0);
        check("done_ready", 128'(in_ready), 128'd0);
        held = ct;
        for (int i = 0; i < bp; i++) begin
            step();
            check("bp_valid", 128'(out_valid), 128'd1);
            check("bp_ct", ct, held);
            check("bp_ready", 128'(in_ready), 128'd0);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("hs_ready", 128'(in_ready), 128'd1);
        check("hs_valid", 128'(out_valid), 128'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int           cyc;
        int           pulses;
        logic [127:0] p1, k1, p2, k2, e1, e2;

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        pt        = '0;
        key       = '0;
        step();
        step();
        rst = 1'b0;

        // Reset state.
        check("rst_in_ready", 128'(in_ready), 128'd1);
        check("rst_out_valid", 128'(out_valid), 128'd0);
        check("rst_round", 128'(round), 128'd0);
        check("rst_rcon", 128'(rcon), 128'h01);
        check("rst_mix_en", 128'(mix_en), 128'd0);
        check("rst_state", dut_state, 128'd0);
        check("rst_key", dut_key, 128'd0);

        // FIPS-197 C.1 with per-round trace and 5 cycles of backpressure.
        run_block(C1_PT, C1_KEY, C1_CT, 5, 1'b0, 1'b1);
        // Same vector with an ignored busy input pulse.
        run_block(C1_PT, C1_KEY, C1_CT, 0, 1'b1, 1'b1);

        // Reset in round 5, then the vector again.
        pt       = C1_PT;
        key      = C1_KEY;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        for (int i = 1; i < 5; i++) step();
        check("pre_rst_round", 128'(round), 128'd5);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("abort_ready", 128'(in_ready), 128'd1);
        check("abort_round", 128'(round), 128'd0);
        check("abort_valid", 128'(out_valid), 128'd0);
        pulses = 0;
        for (int i = 0; i < 15; i++) begin
            if (out_valid) pulses++;
            step();
        end
        check("abort_no_pulse", 128'(pulses), 128'd0);
        run_block(C1_PT, C1_KEY, C1_CT, 1, 1'b0, 1'b0);

        // Back-to-back with in_valid held high and out_ready high.
        p1 = rand128(); k1 = rand128(); p2 = rand128(); k2 = rand128();
        e1 = aes_ref(p1, k1);
        e2 = aes_ref(p2, k2);
        pt        = p1;
        key       = k1;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        step();
        pt  = p2;
        key = k2;
        cyc = 1;
        while (!out_valid && cyc < 40) begin
            step();
            cyc++;
        end
        check("b2b_lat1", 128'(cyc), 128'(LAT));
        check("b2b_ct1", ct, e1);
        step();
        check("b2b_ready", 128'(in_ready), 128'd1);
        step();
        in_valid = 1'b0;
        check("b2b_round", 128'(round), 128'd1);
        cyc = 1;
        while (!out_valid && cyc < 40) begin
            step();
            cyc++;
        end
        check("b2b_lat2", 128'(cyc), 128'(LAT));
        check("b2b_ct2", ct, e2);
        step();
        out_ready = 1'b0;
        check("b2b_idle", 128'(in_ready), 128'd1);

        // Randomized blocks against the reference model.
        for (int n = 0; n < 16; n++) begin
            int gap;
            gap = int'($urandom_range(0, 2));
            for (int g = 0; g < gap; g++) step();
            p1 = rand128();
            k1 = rand128();
            run_block(p1, k1, aes_ref(p1, k1), int'($urandom_range(0, 4)),
                      1'($urandom_range(0, 1)), 1'b1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_aes_round_ctrl
